// File: rtl/mvu_pkg.sv
// Shared types and constants for the MVU input path.
// Holds the transposer FSM states, the precision type and the block geometry.
package mvu_pkg;

  localparam int N        = 64;
  localparam int BDBANKA  = 15;
  localparam int MAX_PREC = 16;
  localparam int PREC_W   = 5;

  typedef logic [PREC_W-1:0] prec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic prec_legal(input prec_t p, input int max_prec);
    return (p != '0) && (int'(p) <= max_prec);
  endfunction

endpackage

// File: rtl/mvu_bitplane_select.sv
// Combinational bit-plane extraction: bit bit_idx of every element, packed
// into one word with element i at bit i.
module mvu_bitplane_select #(
  parameter int NUM_ELEM = mvu_pkg::N,
  parameter int MAX_PREC = mvu_pkg::MAX_PREC,
  parameter int BIT_W    = $clog2(MAX_PREC)
) (
  input  logic [NUM_ELEM*MAX_PREC-1:0] elems,
  input  logic [BIT_W-1:0]             bit_idx,
  output logic [NUM_ELEM-1:0]          plane
);

  generate
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
      logic [MAX_PREC-1:0] elem;
      assign elem      = elems[gi*MAX_PREC +: MAX_PREC];
      assign plane[gi] = elem[bit_idx];
    end
  endgenerate

endmodule

// File: rtl/mvu_input_transposer.sv
// Buffers NUM_ELEM element values from pito, then writes them to the MVU data
// RAM as bit planes, MSB plane first, one RAM word per precision bit.
module mvu_input_transposer #(
  parameter int NUM_ELEM = mvu_pkg::N,
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = mvu_pkg::BDBANKA,
  parameter int MAX_PREC = mvu_pkg::MAX_PREC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [4:0]          cfg_prec,
  input  logic [ADDR_LEN-1:0] cfg_baddr,
  input  logic                cfg_stop,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_word,
  output logic                busy,
  output logic                err_prec,
  output logic                wr_en,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic [NUM_ELEM-1:0] wr_word
);
  import mvu_pkg::state_t;
  import mvu_pkg::IDLE;
  import mvu_pkg::FILL;
  import mvu_pkg::DRAIN;
  import mvu_pkg::prec_t;
  import mvu_pkg::prec_legal;

  localparam int CNT_W  = $clog2(NUM_ELEM + 1);
  localparam int BIT_W  = $clog2(MAX_PREC);
  localparam int PREC_W = $bits(prec_t);

  state_t              state_reg, state_next;
  prec_t               prec_reg;
  logic [ADDR_LEN-1:0] addr_ptr_reg;
  logic [CNT_W-1:0]    elem_cnt_reg;
  logic [BIT_W-1:0]    plane_reg, plane_next;
  logic                stop_pend_reg;
  logic                err_prec_reg;
  logic                wr_en_reg, wr_en_next;
  logic [ADDR_LEN-1:0] wr_addr_reg, wr_addr_next;
  logic [NUM_ELEM-1:0] wr_word_reg, wr_word_next;
  logic [MAX_PREC-1:0] elem_buf_reg [NUM_ELEM];

  logic                        hs, start_ok, last_elem, last_plane, drain_done;
  logic [MAX_PREC-1:0]         prec_mask, in_masked;
  logic [NUM_ELEM*MAX_PREC-1:0] elem_flat;
  logic [PREC_W-1:0]           bit_sel;
  logic [NUM_ELEM-1:0]         plane_word;
  logic                        unused_bits;

  assign hs         = in_valid && (state_reg == FILL);
  assign start_ok   = cfg_start && prec_legal(cfg_prec, MAX_PREC);
  assign last_elem  = hs && (elem_cnt_reg == CNT_W'(NUM_ELEM - 1));
  assign last_plane = (PREC_W'(plane_reg) == prec_reg - PREC_W'(1));
  assign drain_done = (state_reg == DRAIN) && (state_next != DRAIN);
  assign in_masked  = in_word[MAX_PREC-1:0] & prec_mask;
  assign unused_bits = &{1'b0, in_word[XLEN-1:MAX_PREC], bit_sel[PREC_W-1]};

  // The plane written on entry to DRAIN must already include the element
  // accepted on that same edge, so planes are taken from the post-write view.
  generate
    for (genvar gi = 0; gi < MAX_PREC; gi++) begin : g_mask
      assign prec_mask[gi] = (PREC_W'(gi) < prec_reg);
    end
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_flat
      assign elem_flat[gi*MAX_PREC +: MAX_PREC] =
        (hs && (elem_cnt_reg == CNT_W'(gi))) ? in_masked : elem_buf_reg[gi];
    end
  endgenerate

  assign bit_sel = prec_reg - PREC_W'(1) - PREC_W'(plane_next);

  mvu_bitplane_select #(
    .NUM_ELEM (NUM_ELEM),
    .MAX_PREC (MAX_PREC),
    .BIT_W    (BIT_W)
  ) u_select (
    .elems   (elem_flat),
    .bit_idx (bit_sel[BIT_W-1:0]),
    .plane   (plane_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start_ok) state_next = FILL;
      FILL: begin
        if (last_elem)     state_next = DRAIN;
        else if (cfg_stop) state_next = (hs || elem_cnt_reg != '0) ? DRAIN : IDLE;
      end
      DRAIN: if (last_plane) state_next = (stop_pend_reg || cfg_stop) ? IDLE : FILL;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_reg == FILL);
    busy         = (state_reg != IDLE);
    plane_next   = (state_reg == DRAIN) ? plane_reg + 1'b1 : '0;
    wr_en_next   = (state_next == DRAIN);
    wr_addr_next = wr_en_next ? addr_ptr_reg : '0;
    wr_word_next = wr_en_next ? plane_word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prec_reg      <= '0;
      addr_ptr_reg  <= '0;
      elem_cnt_reg  <= '0;
      plane_reg     <= '0;
      stop_pend_reg <= 1'b0;
      err_prec_reg  <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_word_reg   <= '0;
      for (int i = 0; i < NUM_ELEM; i++) elem_buf_reg[i] <= '0;
    end else begin
      err_prec_reg <= (state_reg == IDLE) && cfg_start && !start_ok;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_word_reg  <= wr_word_next;

      if (state_reg == IDLE && start_ok) begin
        prec_reg     <= cfg_prec;
        addr_ptr_reg <= cfg_baddr;
      end else if (state_next == DRAIN) begin
        addr_ptr_reg <= addr_ptr_reg + 1'b1;
      end

      if (state_next == DRAIN) plane_reg <= plane_next;

      if (state_next != FILL) elem_cnt_reg <= '0;
      else if (hs)            elem_cnt_reg <= elem_cnt_reg + 1'b1;

      if (state_next == IDLE)                      stop_pend_reg <= 1'b0;
      else if (cfg_stop && state_reg != IDLE)      stop_pend_reg <= 1'b1;

      // Clearing after each drain makes a flushed partial block read as zeros.
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (drain_done)
          elem_buf_reg[i] <= '0;
        else if (hs && elem_cnt_reg == CNT_W'(i))
          elem_buf_reg[i] <= in_masked;
      end
    end
  end

  assign err_prec = err_prec_reg;
  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_word  = wr_word_reg;

endmodule

// File: tb/tb_mvu_input_transposer.sv
// Scoreboard bench: stimulus pushes expected bit-plane writes computed from
// element values; a negedge monitor pops and compares each RAM write.
module tb_mvu_input_transposer;
  localparam int NE = 64;
  localparam int AL = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start, cfg_stop, in_valid;
  logic [4:0]    cfg_prec;
  logic [AL-1:0] cfg_baddr;
  logic [31:0]   in_word;
  logic          in_ready, busy, err_prec, wr_en;
  logic [AL-1:0] wr_addr;
  logic [NE-1:0] wr_word;

  always #5 clk = ~clk;

  mvu_input_transposer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_prec  (cfg_prec),
    .cfg_baddr (cfg_baddr),
    .cfg_stop  (cfg_stop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .busy      (busy),
    .err_prec  (err_prec),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_word   (wr_word)
  );

  typedef struct packed {
    logic [AL-1:0] addr;
    logic [NE-1:0] word;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            errors = 0;
  int            checks = 0;
  int            pop_count = 0;
  logic [AL-1:0] model_addr;
  int            model_prec;
  logic [15:0]   blk [NE];
  int            blk_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] pmask(input int p);
    if (p >= 16) return 16'hFFFF;
    return 16'((32'd1 << p) - 1);
  endfunction

  // Reference: plane k holds bit (prec-1-k) of every element, addresses run on.
  task automatic push_block();
    for (int k = 0; k < model_prec; k++) begin
      logic [NE-1:0] w;
      w = '0;
      for (int i = 0; i < NE; i++) w[i] = blk[i][model_prec-1-k];
      exp_q.push_back('{addr: model_addr, word: w});
      model_addr = model_addr + 1'b1;
    end
    for (int i = 0; i < NE; i++) blk[i] = '0;
    blk_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%h word=%h required=no write", wr_addr, wr_word);
      end else begin
        mon_e = exp_q.pop_front();
        pop_count++;
        if (wr_addr !== mon_e.addr || wr_word !== mon_e.word) begin
          errors++;
          $display("FAIL write actual addr=%h word=%h required addr=%h word=%h",
                   wr_addr, wr_word, mon_e.addr, mon_e.word);
        end else begin
          $display("write addr=%h word=%h ok", wr_addr, wr_word);
        end
      end
    end
  end

  task automatic send(input logic [31:0] v, output int waits);
    bit done;
    done = 0;
    waits = 0;
    in_valid = 1'b1;
    in_word = v;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else begin
        waits++;
        if (waits > 200) begin
          chk("ready_timeout", 64'(in_ready), 64'd1);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v, input int gap, output int waits);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    send(v, waits);
    blk[blk_cnt] = v[15:0] & pmask(model_prec);
    blk_cnt++;
    if (blk_cnt == NE) push_block();
  endtask

  task automatic start(input int p, input logic [AL-1:0] a, input bit with_stop);
    cfg_start = 1'b1;
    cfg_prec  = 5'(p);
    cfg_baddr = a;
    cfg_stop  = with_stop;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    if (p >= 1 && p <= 16) begin
      model_prec = p;
      model_addr = a;
      blk_cnt = 0;
      for (int i = 0; i < NE; i++) blk[i] = '0;
    end
  endtask

  task automatic stop();
    cfg_stop = 1'b1;
    @(posedge clk);
    #1;
    cfg_stop = 1'b0;
    if (blk_cnt > 0) push_block();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 500);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, p, nb, n, target;
    logic [31:0] a;
    rst_n = 1'b0; cfg_start = 0; cfg_stop = 0; in_valid = 0;
    cfg_prec = '0; cfg_baddr = '0; in_word = '0; blk_cnt = 0; model_prec = 1; model_addr = '0;
    for (int i = 0; i < NE; i++) blk[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_en", 64'(wr_en), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_err_prec", 64'(err_prec), 64'd0);
    chk("reset_wr_addr", 64'(wr_addr), 64'd0);
    chk("reset_wr_word", wr_word, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // prec 2, i%4 pattern
    start(2, 15'h100, 1'b0);
    chk("start_busy", 64'(busy), 64'd1);
    for (int i = 0; i < NE; i++) feed(32'(i % 4), 0, w);
    @(negedge clk);
    chk("first_wr_latency", 64'(wr_en), 64'd1);
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    stop();
    wait_idle();

    // prec 16, upper input bits ignored
    start(16, 15'h200, 1'b0);
    for (int i = 0; i < NE; i++) feed(32'hFFFF_8001, 0, w);
    stop();
    wait_idle();

    // back-to-back blocks across the address wrap
    start(4, 15'h7FFE, 1'b0);
    for (int i = 0; i < 2 * NE; i++) begin
      feed($urandom, 0, w);
      if (i == NE) chk("ready_low_cycles", 64'(w), 64'd4);
    end
    stop();
    wait_idle();

    // illegal precisions
    for (int j = 0; j < 2; j++) begin
      cfg_start = 1'b1;
      cfg_prec  = (j == 0) ? 5'd0 : 5'd17;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      chk("err_prec_pulse", 64'(err_prec), 64'd1);
      chk("err_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk("err_prec_clear", 64'(err_prec), 64'd0);
    end

    // start and stop together in IDLE: start wins; then empty stop returns to IDLE
    start(5, 15'h050, 1'b1);
    chk("start_wins_busy", 64'(busy), 64'd1);
    stop();
    chk("stop_empty_idle", 64'(busy), 64'd0);

    // partial block flush
    start(3, 15'h300, 1'b0);
    for (int i = 0; i < 10; i++) feed(32'h7, 0, w);
    stop();
    wait_idle();

    // reset during drain
    start(8, 15'h400, 1'b0);
    for (int i = 0; i < NE; i++) feed($urandom, 0, w);
    target = pop_count + 3;
    n = 0;
    while (pop_count < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reset_mid_wait", 64'(pop_count >= target), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_wr_en", 64'(wr_en), 64'd0);
    chk("reset_mid_busy", 64'(busy), 64'd0);
    exp_q.delete();
    blk_cnt = 0;
    for (int i = 0; i < NE; i++) blk[i] = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", 64'(busy), 64'd0);
    chk("post_reset_wr_en", 64'(wr_en), 64'd0);
    start(8, 15'h400, 1'b0);
    for (int i = 0; i < NE; i++) feed($urandom, 0, w);
    stop();
    wait_idle();

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(1, 16));
      a = $urandom;
      start(p, a[AL-1:0], 1'b0);
      nb = int'($urandom_range(1, 2));
      for (int i = 0; i < NE * nb; i++) begin
        feed($urandom, int'($urandom_range(0, 2)), w);
        if (r == 0 && i == 5) begin
          cfg_start = 1'b1;
          cfg_prec  = (p == 16) ? 5'd1 : 5'(p + 1);
          cfg_baddr = '0;
          @(posedge clk); #1;
          cfg_start = 1'b0;
          chk("busy_start_no_err", 64'(err_prec), 64'd0);
        end
      end
      n = int'($urandom_range(0, NE - 1));
      for (int i = 0; i < n; i++) feed($urandom, int'($urandom_range(0, 2)), w);
      stop();
      wait_idle();
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
